// File: rtl/soc_boot_sequencer.sv
// Power-up and reset sequencer: brings up the MMCM, qualifies lock, times the SoC reset release,
// and raises fetch_enable at a latched boot address. Also handles lock loss, button and soft resets.
module soc_boot_sequencer #(
    parameter int unsigned MMCM_RST_CYCLES    = 4,
    parameter int unsigned LOCK_TIMEOUT       = 64,
    parameter int unsigned LOCK_STABLE_CYCLES = 8,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned FETCH_DELAY        = 4,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned DEBOUNCE_CYCLES    = 8,
    parameter logic [31:0] BOOT_ADDR_0        = 32'h1A00_0080,
    parameter logic [31:0] BOOT_ADDR_1        = 32'h1C00_0000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        mmcm_locked,
    output logic        mmcm_rst,
    input  logic        btn_reset,
    input  logic        sw_reset_req,
    input  logic        boot_sel,
    output logic        soc_reset_n,
    output logic        fetch_enable,
    output logic [31:0] boot_addr,
    output logic        fault,
    output logic [2:0]  state,
    output logic [7:0]  lock_loss_cnt
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CntMax = max2(max2(max2(MMCM_RST_CYCLES, LOCK_TIMEOUT),
                                               max2(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)),
                                          FETCH_DELAY);
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        StMmcmRst    = 3'd0,
        StWaitLock   = 3'd1,
        StLockStable = 3'd2,
        StHoldRst    = 3'd3,
        StPreFetch   = 3'd4,
        StRun        = 3'd5,
        StFault      = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RetryW-1:0]   retry_q, retry_d, retry_inc;
    logic [7:0]          llc_q, llc_d;
    logic [31:0]         boot_addr_q, boot_addr_d;
    logic                mmcm_rst_q, mmcm_rst_d;
    logic                soc_reset_n_q, soc_reset_n_d;
    logic                fetch_enable_q, fetch_enable_d;
    logic                fault_q, fault_d;
    logic                lock_s1_q, lock_s2_q;
    logic                btn_s1_q, btn_s2_q;
    logic                btn_db_q, btn_db_d;
    logic                btn_db_prev_q;
    logic [DbW-1:0]      db_cnt_q, db_cnt_d;
    logic                locked, btn_rise;

    assign locked   = lock_s2_q;
    assign btn_rise = btn_db_q & ~btn_db_prev_q;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        retry_inc = retry_q + RetryW'(1);
        llc_d     = llc_q;
        case (state_q)
            StMmcmRst: begin
                if (cnt_q == CntW'(MMCM_RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked) begin
                    state_d = StLockStable;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RetryW'(MAX_RETRIES)) ? StFault : StMmcmRst;
                end
            end
            StLockStable: begin
                if (!locked) begin
                    state_d = StWaitLock;
                end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = StHoldRst;
                end
            end
            StHoldRst: begin
                if (!locked) begin
                    state_d = StMmcmRst;
                    llc_d   = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
                end else if (!btn_db_q && cnt_q == CntW'(RESET_HOLD_CYCLES - 1)) begin
                    state_d = StPreFetch;
                end
            end
            StPreFetch, StRun: begin
                if (!locked) begin
                    state_d = StMmcmRst;
                    llc_d   = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
                end else if (btn_rise || sw_reset_req) begin
                    state_d = StHoldRst;
                end else if (state_q == StPreFetch && cnt_q == CntW'(FETCH_DELAY - 1)) begin
                    state_d = StRun;
                end
            end
            default: state_d = StFault;
        endcase

        if (state_d == StRun) retry_d = '0;

        // Every state entry restarts the counter; a held button freezes the reset hold at zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StHoldRst && btn_db_q) begin
            cnt_d = '0;
        end else if (state_q == StRun || state_q == StFault) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        mmcm_rst_d     = (state_d == StMmcmRst);
        soc_reset_n_d  = (state_d == StPreFetch) || (state_d == StRun);
        fetch_enable_d = (state_d == StRun);
        fault_d        = (state_d == StFault);
        boot_addr_d    = boot_addr_q;
        if (state_d == StPreFetch && state_q != StPreFetch) begin
            boot_addr_d = boot_sel ? BOOT_ADDR_1 : BOOT_ADDR_0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= StMmcmRst;
            cnt_q          <= '0;
            retry_q        <= '0;
            llc_q          <= '0;
            boot_addr_q    <= BOOT_ADDR_0;
            mmcm_rst_q     <= 1'b1;
            soc_reset_n_q  <= 1'b0;
            fetch_enable_q <= 1'b0;
            fault_q        <= 1'b0;
            lock_s1_q      <= 1'b0;
            lock_s2_q      <= 1'b0;
            btn_s1_q       <= 1'b0;
            btn_s2_q       <= 1'b0;
            btn_db_q       <= 1'b0;
            btn_db_prev_q  <= 1'b0;
            db_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            llc_q          <= llc_d;
            boot_addr_q    <= boot_addr_d;
            mmcm_rst_q     <= mmcm_rst_d;
            soc_reset_n_q  <= soc_reset_n_d;
            fetch_enable_q <= fetch_enable_d;
            fault_q        <= fault_d;
            lock_s1_q      <= mmcm_locked;
            lock_s2_q      <= lock_s1_q;
            btn_s1_q       <= btn_reset;
            btn_s2_q       <= btn_s1_q;
            btn_db_q       <= btn_db_d;
            btn_db_prev_q  <= btn_db_q;
            db_cnt_q       <= db_cnt_d;
        end
    end

    assign mmcm_rst      = mmcm_rst_q;
    assign soc_reset_n   = soc_reset_n_q;
    assign fetch_enable  = fetch_enable_q;
    assign boot_addr     = boot_addr_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_soc_boot_sequencer.sv
// Directed bench for soc_boot_sequencer: boot, lock timeout, lock glitches, button, soft reset.
module tb_soc_boot_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        mmcm_locked;
    logic        mmcm_rst;
    logic        btn_reset;
    logic        sw_reset_req;
    logic        boot_sel;
    logic        soc_reset_n;
    logic        fetch_enable;
    logic [31:0] boot_addr;
    logic        fault;
    logic [2:0]  state;
    logic [7:0]  lock_loss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    soc_boot_sequencer dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mmcm_locked  (mmcm_locked),
        .mmcm_rst     (mmcm_rst),
        .btn_reset    (btn_reset),
        .sw_reset_req (sw_reset_req),
        .boot_sel     (boot_sel),
        .soc_reset_n  (soc_reset_n),
        .fetch_enable (fetch_enable),
        .boot_addr    (boot_addr),
        .fault        (fault),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Number of consecutive samples (including the current one) spent in state st.
    task automatic measure_run(input logic [2:0] st, output int n);
        n = 0;
        while (state == st && n < 500) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        int i;
        ok = 0;
        i  = 0;
        while (!ok && i <= budget) begin
            if (state == st) ok = 1;
            else begin
                tick();
                i++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mmcm_locked = 1'b0; btn_reset = 1'b0; sw_reset_req = 1'b0; boot_sel = 1'b0;
        repeat (3) tick();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state); end
        n_cmp++; if (mmcm_rst !== 1'b1) begin n_err++; $display("FAIL rst_mmcm got %0b want 1", mmcm_rst); end
        n_cmp++; if (soc_reset_n !== 1'b0) begin n_err++; $display("FAIL rst_srn got %0b want 0", soc_reset_n); end
        n_cmp++; if (fetch_enable !== 1'b0) begin n_err++; $display("FAIL rst_fe got %0b want 0", fetch_enable); end
        n_cmp++; if (boot_addr !== 32'h1A00_0080) begin n_err++; $display("FAIL rst_addr got %h want 1a000080", boot_addr); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %0b want 0", fault); end
        n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_err++; $display("FAIL rst_llc got %0d want 0", lock_loss_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_lock_timeout();
        int n;
        for (int a = 0; a < 3; a++) begin
            measure_run(3'd0, n);
            n_cmp++; if (n !== 4) begin n_err++; $display("FAIL to_rst_len[%0d] got %0d want 4", a, n); end
            measure_run(3'd1, n);
            n_cmp++; if (n !== 64) begin n_err++; $display("FAIL to_wait_len[%0d] got %0d want 64", a, n); end
        end
        n_cmp++; if (state !== 3'd6) begin n_err++; $display("FAIL to_state got %0d want 6", state); end
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL to_fault got %0b want 1", fault); end
        n_cmp++; if (mmcm_rst !== 1'b0) begin n_err++; $display("FAIL to_mmcm got %0b want 0", mmcm_rst); end
        mmcm_locked = 1'b1;
        repeat (20) tick();
        n_cmp++; if (state !== 3'd6) begin n_err++; $display("FAIL fault_sticky got %0d want 6", state); end
        reset = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL fault_rst_state got %0d want 0", state); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_rst_fault got %0b want 0", fault); end
        n_cmp++; if (mmcm_rst !== 1'b1) begin n_err++; $display("FAIL fault_rst_mmcm got %0b want 1", mmcm_rst); end
        tick();
        reset = 1'b0;
    endtask

    // Runs from LOCK_STABLE entry to RUN, checking each phase length.
    task automatic check_boot(input string tag, input logic [31:0] exp_addr);
        int n;
        bit ok;
        wait_state(3'd2, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_reach_stable got %0d want 2", tag, state); end
        measure_run(3'd2, n);
        n_cmp++; if (n !== 8) begin n_err++; $display("FAIL %s_stable_len got %0d want 8", tag, n); end
        measure_run(3'd3, n);
        n_cmp++; if (n !== 16) begin n_err++; $display("FAIL %s_hold_len got %0d want 16", tag, n); end
        n_cmp++; if (soc_reset_n !== 1'b1 || fetch_enable !== 1'b0) begin
            n_err++; $display("FAIL %s_prefetch_out got srn=%0b fe=%0b want srn=1 fe=0", tag, soc_reset_n, fetch_enable); end
        measure_run(3'd4, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL %s_prefetch_len got %0d want 4", tag, n); end
        n_cmp++; if (state !== 3'd5 || fetch_enable !== 1'b1) begin
            n_err++; $display("FAIL %s_run got state=%0d fe=%0b want state=5 fe=1", tag, state, fetch_enable); end
        n_cmp++; if (boot_addr !== exp_addr) begin n_err++; $display("FAIL %s_addr got %h want %h", tag, boot_addr, exp_addr); end
    endtask

    task automatic test_nominal();
        check_boot("nom", 32'h1A00_0080);
        n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_err++; $display("FAIL nom_llc got %0d want 0", lock_loss_cnt); end
    endtask

    task automatic test_lock_glitch();
        bit ok;
        mmcm_locked = 1'b0;
        tick(); tick();
        n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL gl_sync_delay got %0d want 5", state); end
        tick();
        n_cmp++; if (state !== 3'd0 || fetch_enable !== 1'b0 || soc_reset_n !== 1'b0) begin
            n_err++; $display("FAIL gl_run_drop got state=%0d fe=%0b srn=%0b want 0/0/0", state, fetch_enable, soc_reset_n); end
        n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_err++; $display("FAIL gl_llc1 got %0d want 1", lock_loss_cnt); end
        mmcm_locked = 1'b1;
        wait_state(3'd2, 50, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL gl_relock got %0d want 2", state); end
        repeat (3) tick();
        mmcm_locked = 1'b0;
        tick();
        mmcm_locked = 1'b1;
        wait_state(3'd1, 6, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL gl_stable_drop got %0d want 1", state); end
        n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_err++; $display("FAIL gl_llc_stable got %0d want 1", lock_loss_cnt); end
        check_boot("gl", 32'h1A00_0080);
    endtask

    task automatic test_button();
        int n;
        bit saw_mmcm;
        saw_mmcm = 0;
        btn_reset = 1'b1;
        repeat (3) tick();
        btn_reset = 1'b0;
        repeat (20) begin tick(); if (mmcm_rst) saw_mmcm = 1; end
        n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL btn_bounce got %0d want 5", state); end
        btn_reset = 1'b1;
        repeat (20) begin tick(); if (mmcm_rst) saw_mmcm = 1; end
        n_cmp++; if (state !== 3'd3 || soc_reset_n !== 1'b0) begin
            n_err++; $display("FAIL btn_hold got state=%0d srn=%0b want 3/0", state, soc_reset_n); end
        btn_reset = 1'b0;
        repeat (25) begin tick(); if (mmcm_rst) saw_mmcm = 1; end
        n_cmp++; if (state !== 3'd3 || soc_reset_n !== 1'b0) begin
            n_err++; $display("FAIL btn_release_hold got state=%0d srn=%0b want 3/0", state, soc_reset_n); end
        tick();
        n_cmp++; if (state !== 3'd4 || soc_reset_n !== 1'b1) begin
            n_err++; $display("FAIL btn_release_pf got state=%0d srn=%0b want 4/1", state, soc_reset_n); end
        measure_run(3'd4, n);
        n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL btn_run got %0d want 5", state); end
        n_cmp++; if (saw_mmcm) begin n_err++; $display("FAIL btn_mmcm got 1 want 0"); end
    endtask

    task automatic test_soft_reset();
        int n;
        boot_sel = 1'b1;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        n_cmp++; if (state !== 3'd3 || fetch_enable !== 1'b0 || soc_reset_n !== 1'b0) begin
            n_err++; $display("FAIL sw_enter got state=%0d fe=%0b srn=%0b want 3/0/0", state, fetch_enable, soc_reset_n); end
        measure_run(3'd3, n);
        n_cmp++; if (n !== 16) begin n_err++; $display("FAIL sw_hold_len got %0d want 16", n); end
        n_cmp++; if (boot_addr !== 32'h1C00_0000) begin n_err++; $display("FAIL sw_addr got %h want 1c000000", boot_addr); end
        measure_run(3'd4, n);
        boot_sel = 1'b0;
        repeat (5) tick();
        n_cmp++; if (state !== 3'd5 || boot_addr !== 32'h1C00_0000) begin
            n_err++; $display("FAIL sw_addr_hold got state=%0d addr=%h want 5/1c000000", state, boot_addr); end
    endtask

    task automatic test_coincident();
        bit ok;
        mmcm_locked = 1'b0;
        tick(); tick();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        n_cmp++; if (state !== 3'd0 || mmcm_rst !== 1'b1) begin
            n_err++; $display("FAIL co_state got state=%0d mmcm=%0b want 0/1", state, mmcm_rst); end
        n_cmp++; if (lock_loss_cnt !== 8'd2) begin n_err++; $display("FAIL co_llc got %0d want 2", lock_loss_cnt); end
        mmcm_locked = 1'b1;
        boot_sel = 1'b1;
        wait_state(3'd4, 200, ok);
        n_cmp++; if (!ok || boot_addr !== 32'h1C00_0000) begin
            n_err++; $display("FAIL co_prefetch got state=%0d addr=%h want 4/1c000000", state, boot_addr); end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd0 || mmcm_rst !== 1'b1 || soc_reset_n !== 1'b0 || fetch_enable !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_out got state=%0d mmcm=%0b srn=%0b fe=%0b want 0/1/0/0",
                              state, mmcm_rst, soc_reset_n, fetch_enable); end
        n_cmp++; if (boot_addr !== 32'h1A00_0080 || fault !== 1'b0 || lock_loss_cnt !== 8'd0) begin
            n_err++; $display("FAIL mid_rst_regs got addr=%h fault=%0b llc=%0d want 1a000080/0/0",
                              boot_addr, fault, lock_loss_cnt); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_timeout();
        test_nominal();
        test_lock_glitch();
        test_button();
        test_soft_reset();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/soc_boot_sequencer.md
Name: soc_boot_sequencer

Overview:
Power-up and reset sequencer between the clock MMCM and the RISC-V SoC on the FPGA top level, running on the raw board clock. It resets the MMCM, waits for a stable lock and holds the SoC in reset for a fixed time. It then releases reset and asserts fetch_enable at a latched boot address. It also handles lock loss, pushbutton and software reset requests, and a lock-timeout fault.

Parameters:
MMCM_RST_CYCLES, 4, cycles mmcm_rst is held high per attempt
LOCK_TIMEOUT, 64, max cycles in WAIT_LOCK before a retry
LOCK_STABLE_CYCLES, 8, consecutive locked cycles required
RESET_HOLD_CYCLES, 16, cycles soc_reset_n is held low
FETCH_DELAY, 4, cycles between reset release and fetch_enable
MAX_RETRIES, 3, lock timeouts tolerated before FAULT
DEBOUNCE_CYCLES, 8, stable cycles for button debounce
BOOT_ADDR_0, 32'h1A00_0080, boot address when boot_sel=0
BOOT_ADDR_1, 32'h1C00_0000, boot address when boot_sel=1

Ports:
clk_sys  in  1  board clock, the only clock
reset  in  1  synchronous active-high reset
mmcm_locked  in  1  MMCM lock, asynchronous; 2-FF synchronized internally
mmcm_rst  out  1  active-high reset to the MMCM
btn_reset  in  1  raw pushbutton, active-high, asynchronous
sw_reset_req  in  1  single-cycle soft reset pulse, clk_sys domain
boot_sel  in  1  boot address select, sampled on entry to PRE_FETCH
soc_reset_n  out  1  active-low SoC reset
fetch_enable  out  1  core fetch enable
boot_addr  out  32  core boot address
fault  out  1  lock never achieved
state  out  3  current state, for debug
lock_loss_cnt  out  8  saturating count of lock losses after lock was qualified

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered and change on the edge that enters a state.
- Reset values: state=MMCM_RST, mmcm_rst=1, soc_reset_n=0, fetch_enable=0, boot_addr=BOOT_ADDR_0, fault=0, lock_loss_cnt=0, retry count=0. Reset asserted mid-operation returns all of these on the next edge.
- Synchronizers: mmcm_locked and btn_reset each pass through 2 FFs. "locked" below means the synchronized value.
- Debounce: the debounced button changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- State encoding: 0 MMCM_RST, 1 WAIT_LOCK, 2 LOCK_STABLE, 3 HOLD_RST, 4 PRE_FETCH, 5 RUN, 6 FAULT.
- MMCM_RST: mmcm_rst=1, soc_reset_n=0, fetch_enable=0. Go to WAIT_LOCK after exactly MMCM_RST_CYCLES cycles.
- WAIT_LOCK: mmcm_rst=0.
  - locked=1 → LOCK_STABLE.
  - LOCK_TIMEOUT cycles without lock → retry count +1. If the new count equals MAX_RETRIES → FAULT, otherwise → MMCM_RST.
- LOCK_STABLE: needs LOCK_STABLE_CYCLES consecutive locked=1, then → HOLD_RST. Any locked=0 → WAIT_LOCK with the timeout counter restarted. No lock-loss count here.
- HOLD_RST: soc_reset_n=0 for RESET_HOLD_CYCLES, then → PRE_FETCH. While the debounced button is high, the hold counter is held at 0.
- PRE_FETCH:
  - On entry: soc_reset_n=1 and boot_addr latched from boot_sel.
  - fetch_enable stays 0 for FETCH_DELAY cycles, then → RUN.
- RUN:
  - fetch_enable=1 and retry count cleared.
  - boot_addr stays constant, even if boot_sel changes.
- Lock loss (locked=0) in HOLD_RST, PRE_FETCH or RUN:
  - → MMCM_RST, with soc_reset_n=0 and fetch_enable=0 on the same edge.
  - lock_loss_cnt +1, saturating at 255.
- Reset requests in PRE_FETCH or RUN:
  - Debounced button rising edge, or sw_reset_req → HOLD_RST with the hold counter restarted. The MMCM is not reset.
  - sw_reset_req is ignored in all other states.
- Priority when events coincide: reset > lock loss > button > sw_reset_req > counter expiry.
- FAULT: mmcm_rst=0, soc_reset_n=0, fetch_enable=0, fault=1. Only reset exits FAULT.
- Counters are sized by $clog2 of the largest cycle parameter and restart on every state entry.

Test Plan:
- Nominal boot: locked rises and stays high. Let E be the edge entering LOCK_STABLE → HOLD_RST at E+8, soc_reset_n=1 at E+24, fetch_enable=1 at E+28, boot_addr=32'h1A00_0080.
- Lock timeout: mmcm_locked held 0 → three mmcm_rst pulses of 4 cycles each, separated by 64-cycle waits. After the third timeout state=6 and fault=1. It stays there until reset, which restores all reset values.
- Lock glitch: locked drops for 1 cycle during LOCK_STABLE → back to WAIT_LOCK, lock_loss_cnt stays 0. Later, a drop during RUN → fetch_enable=0, soc_reset_n=0 and state=0 on the next edge, lock_loss_cnt=1, and the full sequence restarts.
- Button: a 3-cycle bounce is ignored. Holding 20 cycles in RUN → HOLD_RST, and soc_reset_n stays 0 until 16 cycles after the debounced release. mmcm_rst never rises.
- Soft reset with boot_sel: sw_reset_req pulse in RUN with boot_sel=1 → HOLD_RST, then PRE_FETCH latches boot_addr=32'h1C00_0000. Toggling boot_sel during RUN leaves boot_addr unchanged.
- Coincident events: lock loss and sw_reset_req on the same cycle in RUN → state=MMCM_RST and lock_loss_cnt increments. Synchronous reset mid-PRE_FETCH → all reset values on the next edge.
